// File: rtl/click_decoder_pkg.sv
// Shared types, default parameters and width helper for the click decoder.
package click_pkg;

    typedef enum logic {
        IDLE,
        COUNT
    } state_t;

    localparam int unsigned DEF_WINDOW_CYCLES  = 25_000_000;
    localparam int unsigned DEF_MAX_CLICKS     = 3;
    localparam int unsigned DEF_LOCKOUT_CYCLES = 1_000_000;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int unsigned width_for(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/click_decoder_if.sv
// Press-pulse input and gesture report outputs of the click decoder.
interface click_decoder_if #(
    parameter int unsigned CNT_W = click_pkg::width_for(click_pkg::DEF_MAX_CLICKS)
) ();

    logic             press_pulse;
    logic             busy;
    logic             click_valid;
    logic [CNT_W-1:0] click_count;
    logic             click_sat;

    modport master (
        output press_pulse,
        input  busy,
        input  click_valid,
        input  click_count,
        input  click_sat
    );

    modport slave (
        input  press_pulse,
        output busy,
        output click_valid,
        output click_count,
        output click_sat
    );

endinterface

// File: rtl/click_decoder_cycle_timer.sv
// Loadable down-counter that parks at zero; zero_o flags the parked state.
module cycle_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/click_decoder.sv
// Groups debounced press pulses into multi-click gestures and reports the count.
// Optional post-accept pulse lockout is enabled by defining CLICK_LOCKOUT_EN.
module click_decoder
    import click_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES  = DEF_WINDOW_CYCLES,
    parameter int unsigned MAX_CLICKS     = DEF_MAX_CLICKS,
    parameter int unsigned LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
    input logic            clk,
    input logic            rst,
    click_decoder_if.slave bus
);

    localparam int unsigned CNT_W = width_for(MAX_CLICKS);
    localparam int unsigned TW    = width_for(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CLICKS);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
    localparam logic             SAT_ON_FIRST = (MAX_CLICKS == 1);

    if (WINDOW_CYCLES < 2) begin : g_bad_window
        $error("click_decoder: WINDOW_CYCLES must be >= 2");
    end
    if (MAX_CLICKS < 1) begin : g_bad_max
        $error("click_decoder: MAX_CLICKS must be >= 1");
    end
    if (LOCKOUT_CYCLES < 1 || LOCKOUT_CYCLES >= WINDOW_CYCLES) begin : g_bad_lockout
        $error("click_decoder: LOCKOUT_CYCLES must be in [1, WINDOW_CYCLES)");
    end

    logic accept;
    logic win_zero;

`ifdef CLICK_LOCKOUT_EN
    logic lock_zero;

    // Lockout fits the window timer width because LOCKOUT_CYCLES < WINDOW_CYCLES.
    cycle_timer #(.WIDTH(TW)) u_lock_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (accept),
        .load_val_i (TW'(LOCKOUT_CYCLES)),
        .zero_o     (lock_zero)
    );

    assign accept = bus.press_pulse && lock_zero;
`else
    assign accept = bus.press_pulse;
`endif

    cycle_timer #(.WIDTH(TW)) u_win_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (accept),
        .load_val_i (TW'(WINDOW_CYCLES - 1)),
        .zero_o     (win_zero)
    );

    state_t           state_q;
    logic [CNT_W-1:0] acc_q;
    logic             sat_q;
    logic             busy_q;
    logic             valid_q;
    logic [CNT_W-1:0] count_q;
    logic             csat_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            sat_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            count_q <= '0;
            csat_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= COUNT;
                        acc_q   <= ONE_C;
                        sat_q   <= SAT_ON_FIRST;
                        busy_q  <= 1'b1;
                    end
                end
                COUNT: begin
                    if (win_zero) begin
                        count_q <= acc_q;
                        csat_q  <= sat_q;
                        valid_q <= 1'b1;
                        // A pulse on the expiry cycle opens the next gesture directly.
                        if (accept) begin
                            acc_q <= ONE_C;
                            sat_q <= SAT_ON_FIRST;
                        end else begin
                            state_q <= IDLE;
                            acc_q   <= '0;
                            sat_q   <= 1'b0;
                            busy_q  <= 1'b0;
                        end
                    end else if (accept) begin
                        if (acc_q >= MAX_C) begin
                            sat_q <= 1'b1;
                        end else begin
                            acc_q <= acc_q + ONE_C;
                            if (acc_q + ONE_C == MAX_C) begin
                                sat_q <= 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.click_valid = valid_q;
    assign bus.click_count = count_q;
    assign bus.click_sat   = csat_q;

endmodule

// File: tb/tb_click_decoder.sv
// Self-checking bench for click_decoder against a timestamp-based gesture model.
module tb_click_decoder;

    localparam int W     = 10;
    localparam int MAX   = 3;
    localparam int LOCK  = 3;
    localparam int CNT_W = $clog2(MAX + 1);
`ifdef CLICK_LOCKOUT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    click_decoder_if #(.CNT_W(CNT_W)) bus ();

    click_decoder #(
        .WINDOW_CYCLES  (W),
        .MAX_CLICKS     (MAX),
        .LOCKOUT_CYCLES (LOCK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int               cyc;
    int               m_last;
    int               m_cnt;
    bit               m_open;
    logic             exp_busy;
    logic             exp_valid;
    logic             exp_sat;
    logic [CNT_W-1:0] exp_count;

    task automatic model_reset();
        cyc       = 0;
        m_last    = -100000;
        m_open    = 1'b0;
        m_cnt     = 0;
        exp_busy  = 1'b0;
        exp_valid = 1'b0;
        exp_sat   = 1'b0;
        exp_count = '0;
    endtask

    // Drive one sample, then advance the model by the gesture rules:
    // a gesture closes W edges after its last accepted pulse.
    task automatic step(input bit p);
        @(negedge clk);
        bus.press_pulse = p;
        @(posedge clk);
        exp_valid = 1'b0;
        if (m_open && cyc == m_last + W) begin
            exp_valid = 1'b1;
            exp_count = CNT_W'((m_cnt > MAX) ? MAX : m_cnt);
            exp_sat   = (m_cnt >= MAX);
            m_open    = 1'b0;
        end
        if (p && !(LOCK_EN && (cyc - m_last) <= LOCK)) begin
            if (m_open) m_cnt++;
            else begin
                m_open = 1'b1;
                m_cnt  = 1;
            end
            m_last = cyc;
        end
        exp_busy = m_open;
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.press_pulse = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.click_valid, bus.click_count, bus.click_sat} !== '0) begin
            errors++;
            $display("FAIL reset: busy=%b valid=%b count=%0d sat=%b, want all 0",
                     bus.busy, bus.click_valid, bus.click_count, bus.click_sat);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (3) step(1'b0);
    endtask

    task automatic test_single();
        int rep_at[$];
        int rep_cnt[$];
        int rep_sat[$];
        for (int i = 0; i < 20; i++) begin
            step(i == 5);
            checks++;
            if ({bus.busy, bus.click_valid, bus.click_count, bus.click_sat} !==
                {exp_busy, exp_valid, exp_count, exp_sat}) begin
                errors++;
                $display("FAIL single i=%0d: busy/valid/count/sat got %b/%b/%0d/%b want %b/%b/%0d/%b",
                         i, bus.busy, bus.click_valid, bus.click_count, bus.click_sat,
                         exp_busy, exp_valid, exp_count, exp_sat);
            end
            if (bus.click_valid) begin
                rep_at.push_back(i);
                rep_cnt.push_back(int'(bus.click_count));
                rep_sat.push_back(int'(bus.click_sat));
            end
        end
        checks++;
        if (rep_at.size() != 1 || rep_at[0] != 15 || rep_cnt[0] != 1 || rep_sat[0] != 0) begin
            errors++;
            $display("FAIL single_report: got %0d reports first at %0d count %0d sat %0d, want 1 at 15 count 1 sat 0",
                     rep_at.size(), rep_at[0], rep_cnt[0], rep_sat[0]);
        end
    endtask

    task automatic test_double();
        int rep_at[$];
        int rep_cnt[$];
        for (int i = 0; i < 26; i++) begin
            step(i == 5 || i == 12);
            checks++;
            if ({bus.busy, bus.click_valid, bus.click_count, bus.click_sat} !==
                {exp_busy, exp_valid, exp_count, exp_sat}) begin
                errors++;
                $display("FAIL double i=%0d: busy/valid/count/sat got %b/%b/%0d/%b want %b/%b/%0d/%b",
                         i, bus.busy, bus.click_valid, bus.click_count, bus.click_sat,
                         exp_busy, exp_valid, exp_count, exp_sat);
            end
            if (bus.click_valid) begin
                rep_at.push_back(i);
                rep_cnt.push_back(int'(bus.click_count));
            end
        end
        checks++;
        if (rep_at.size() != 1 || rep_at[0] != 22 || rep_cnt[0] != 2) begin
            errors++;
            $display("FAIL double_report: got %0d reports first at %0d count %0d, want 1 at 22 count 2",
                     rep_at.size(), rep_at[0], rep_cnt[0]);
        end
    endtask

    task automatic test_saturate();
        int rep_at[$];
        int rep_cnt[$];
        int rep_sat[$];
        for (int i = 0; i < 32; i++) begin
            step(i inside {2, 6, 10, 14, 18});
            checks++;
            if ({bus.busy, bus.click_valid, bus.click_count, bus.click_sat} !==
                {exp_busy, exp_valid, exp_count, exp_sat}) begin
                errors++;
                $display("FAIL saturate i=%0d: busy/valid/count/sat got %b/%b/%0d/%b want %b/%b/%0d/%b",
                         i, bus.busy, bus.click_valid, bus.click_count, bus.click_sat,
                         exp_busy, exp_valid, exp_count, exp_sat);
            end
            if (bus.click_valid) begin
                rep_at.push_back(i);
                rep_cnt.push_back(int'(bus.click_count));
                rep_sat.push_back(int'(bus.click_sat));
            end
        end
        checks++;
        if (rep_at.size() != 1 || rep_at[0] != 28 || rep_cnt[0] != 3 || rep_sat[0] != 1) begin
            errors++;
            $display("FAIL saturate_report: got %0d reports first at %0d count %0d sat %0d, want 1 at 28 count 3 sat 1",
                     rep_at.size(), rep_at[0], rep_cnt[0], rep_sat[0]);
        end
    endtask

    task automatic test_back_to_back();
        int rep_at[$];
        int rep_cnt[$];
        logic busy_at_expiry = 1'b0;
        for (int i = 0; i < 26; i++) begin
            step(i == 2 || i == 12);
            checks++;
            if ({bus.busy, bus.click_valid, bus.click_count, bus.click_sat} !==
                {exp_busy, exp_valid, exp_count, exp_sat}) begin
                errors++;
                $display("FAIL back_to_back i=%0d: busy/valid/count/sat got %b/%b/%0d/%b want %b/%b/%0d/%b",
                         i, bus.busy, bus.click_valid, bus.click_count, bus.click_sat,
                         exp_busy, exp_valid, exp_count, exp_sat);
            end
            if (i == 12) busy_at_expiry = bus.busy;
            if (bus.click_valid) begin
                rep_at.push_back(i);
                rep_cnt.push_back(int'(bus.click_count));
            end
        end
        checks++;
        if (rep_at.size() != 2 || rep_at[0] != 12 || rep_cnt[0] != 1 ||
            rep_at[1] != 22 || rep_cnt[1] != 1 || busy_at_expiry !== 1'b1) begin
            errors++;
            $display("FAIL back_to_back_report: got %0d reports at %0d/%0d counts %0d/%0d busy %b, want 2 at 12/22 counts 1/1 busy 1",
                     rep_at.size(), rep_at[0], rep_at[1], rep_cnt[0], rep_cnt[1], busy_at_expiry);
        end
    endtask

    task automatic test_mid_reset();
        int reps1 = 0;
        int rep_at[$];
        int rep_cnt[$];
        for (int i = 0; i < 8; i++) begin
            step(i == 2 || i == 5);
            if (bus.click_valid) reps1++;
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.click_valid, bus.click_count, bus.click_sat} !== '0 || reps1 != 0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b valid=%b count=%0d sat=%b reports=%0d, want all 0",
                     bus.busy, bus.click_valid, bus.click_count, bus.click_sat, reps1);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(i == 3);
            checks++;
            if ({bus.busy, bus.click_valid, bus.click_count, bus.click_sat} !==
                {exp_busy, exp_valid, exp_count, exp_sat}) begin
                errors++;
                $display("FAIL mid_reset_after i=%0d: busy/valid/count/sat got %b/%b/%0d/%b want %b/%b/%0d/%b",
                         i, bus.busy, bus.click_valid, bus.click_count, bus.click_sat,
                         exp_busy, exp_valid, exp_count, exp_sat);
            end
            if (bus.click_valid) begin
                rep_at.push_back(i);
                rep_cnt.push_back(int'(bus.click_count));
            end
        end
        checks++;
        if (rep_at.size() != 1 || rep_at[0] != 13 || rep_cnt[0] != 1) begin
            errors++;
            $display("FAIL mid_reset_report: got %0d reports first at %0d count %0d, want 1 at 13 count 1",
                     rep_at.size(), rep_at[0], rep_cnt[0]);
        end
    endtask

    task automatic test_lockout();
        int rep_at[$];
        int rep_cnt[$];
        int want_cnt = LOCK_EN ? 2 : 3;
        for (int i = 0; i < 25; i++) begin
            step(i inside {5, 7, 9});
            checks++;
            if ({bus.busy, bus.click_valid, bus.click_count, bus.click_sat} !==
                {exp_busy, exp_valid, exp_count, exp_sat}) begin
                errors++;
                $display("FAIL lockout i=%0d: busy/valid/count/sat got %b/%b/%0d/%b want %b/%b/%0d/%b",
                         i, bus.busy, bus.click_valid, bus.click_count, bus.click_sat,
                         exp_busy, exp_valid, exp_count, exp_sat);
            end
            if (bus.click_valid) begin
                rep_at.push_back(i);
                rep_cnt.push_back(int'(bus.click_count));
            end
        end
        checks++;
        if (rep_at.size() != 1 || rep_at[0] != 19 || rep_cnt[0] != want_cnt) begin
            errors++;
            $display("FAIL lockout_report: got %0d reports first at %0d count %0d, want 1 at 19 count %0d",
                     rep_at.size(), rep_at[0], rep_cnt[0], want_cnt);
        end
    endtask

    task automatic test_random();
        int rate = 15;
        for (int i = 0; i < 900; i++) begin
            if (i % 60 == 0) rate = (($urandom_range(0, 2) == 0) ? 5 : (($urandom_range(0, 1) == 0) ? 15 : 40));
            step((i < 880) && ($urandom_range(0, 99) < rate));
            checks++;
            if ({bus.busy, bus.click_valid, bus.click_count, bus.click_sat} !==
                {exp_busy, exp_valid, exp_count, exp_sat}) begin
                errors++;
                $display("FAIL random i=%0d: busy/valid/count/sat got %b/%b/%0d/%b want %b/%b/%0d/%b",
                         i, bus.busy, bus.click_valid, bus.click_count, bus.click_sat,
                         exp_busy, exp_valid, exp_count, exp_sat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_double();
        test_saturate();
        test_back_to_back();
        test_mid_reset();
        test_lockout();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
